plank_frame_ctrl: RTL and testbench

Byte-level frame controller between the UART receiver and the PLANK beam-control registers. It hunts for the 21-byte PLANK command frame, checks the XOR checksum and footer, and stages attenuation, phase and channel-power values in shadow registers. A valid frame's values are committed atomically to the channel outputs, either immediately or on the next TR pulse, and are held off while inhibit is asserted.

---
 rtl/plank_frame_ctrl.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_plank_frame_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/plank_frame_ctrl.sv
//------------------------------------------------------------------------------
// plank_frame_ctrl
//   Hunts for the 21-byte PLANK command frame on the UART byte stream, checks
//   XOR checksum and footer, and commits attenuation/phase/power atomically.
//   Optional inter-byte timeout: define PLANK_FRAME_TIMEOUT_EN.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module plank_frame_ctrl #(
`ifdef PLANK_FRAME_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 17360,
`endif
  parameter logic [3:0]  CMD_LOAD       = 4'h2,
  parameter logic [3:0]  CMD_NOP        = 4'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_TR_pulse,
  input  logic        i_inhibit,
  output logic [47:0] o_attn,
  output logic [47:0] o_phase,
  output logic [7:0]  o_ch_power,
  output logic        o_frame_ok,
  output logic        o_frame_err,
  output logic [2:0]  o_err_code,
  output logic [7:0]  o_err_cnt,
  output logic        o_ack_dv,
  output logic [7:0]  o_ack_byte,
  output logic        o_pending,
  output logic        o_busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_FTR  = 3'd4;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_FOOTER  = 3'd1;
  localparam logic [2:0] ERR_CSUM    = 3'd2;
  localparam logic [2:0] ERR_CMD     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  flags_q, flags_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [7:0]  xor_q, xor_d;
  logic        csum_bad_q, csum_bad_d;
  logic [47:0] sh_attn_q, sh_attn_d;
  logic [47:0] sh_phase_q, sh_phase_d;
  logic [7:0]  sh_pwr_q, sh_pwr_d;
  logic [47:0] stg_attn_q, stg_attn_d;
  logic [47:0] stg_phase_q, stg_phase_d;
  logic [7:0]  stg_pwr_q, stg_pwr_d;
  logic [2:0]  stg_en_q, stg_en_d;
  logic        stg_defer_q, stg_defer_d;
  logic        pending_q, pending_d;
  logic [47:0] attn_q, attn_d;
  logic [47:0] phase_q, phase_d;
  logic [7:0]  pwr_q, pwr_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        ack_dv_q, ack_dv_d;
  logic [7:0]  ack_byte_q, ack_byte_d;
  logic        tr_prev_q, tr_prev_d;

  logic        tr_rise;
  logic        accept_load;
  logic [2:0]  ftr_code;
  logic [7:0]  err_cnt_inc;

`ifdef PLANK_FRAME_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign tr_rise     = i_TR_pulse & ~tr_prev_q;
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_comb begin
    if (i_rx_byte != 8'h55) begin
      ftr_code = ERR_FOOTER;
    end else if (csum_bad_q) begin
      ftr_code = ERR_CSUM;
    end else if ((cmd_q != CMD_LOAD) && (cmd_q != CMD_NOP)) begin
      ftr_code = ERR_CMD;
    end else begin
      ftr_code = ERR_NONE;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    flags_d     = flags_q;
    cmd_d       = cmd_q;
    xor_d       = xor_q;
    csum_bad_d  = csum_bad_q;
    sh_attn_d   = sh_attn_q;
    sh_phase_d  = sh_phase_q;
    sh_pwr_d    = sh_pwr_q;
    stg_attn_d  = stg_attn_q;
    stg_phase_d = stg_phase_q;
    stg_pwr_d   = stg_pwr_q;
    stg_en_d    = stg_en_q;
    stg_defer_d = stg_defer_q;
    pending_d   = pending_q;
    attn_d      = attn_q;
    phase_d     = phase_q;
    pwr_d       = pwr_q;
    err_code_d  = err_code_q;
    err_cnt_d   = err_cnt_q;
    ack_byte_d  = ack_byte_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    ack_dv_d    = 1'b0;
    accept_load = 1'b0;
    tr_prev_d   = i_TR_pulse;

    if (i_rx_dv) begin
      case (state_q)
        S_IDLE: begin
          if (i_rx_byte == 8'hAA) state_d = S_CMD;
        end
        S_CMD: begin
          flags_d = i_rx_byte[7:4];
          cmd_d   = i_rx_byte[3:0];
          xor_d   = i_rx_byte;
          idx_d   = 5'd0;
          state_d = S_DATA;
        end
        S_DATA: begin
          xor_d = xor_q ^ i_rx_byte;
          // Index 0..7 attenuation, 8..15 phase, 16 power mask.
          for (int c = 0; c < 8; c++) begin
            if (idx_q == 5'(c))     sh_attn_d[c*6 +: 6]  = i_rx_byte[5:0];
            if (idx_q == 5'(c + 8)) sh_phase_d[c*6 +: 6] = i_rx_byte[5:0];
          end
          if (idx_q == 5'd16) begin
            sh_pwr_d = i_rx_byte;
            state_d  = S_CSUM;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        S_CSUM: begin
          csum_bad_d = (i_rx_byte != xor_q);
          state_d    = S_FTR;
        end
        S_FTR: begin
          state_d  = S_IDLE;
          ack_dv_d = 1'b1;
          if (ftr_code != ERR_NONE) begin
            frame_err_d = 1'b1;
            err_code_d  = ftr_code;
            err_cnt_d   = err_cnt_inc;
            ack_byte_d  = {4'hE, 1'b0, ftr_code};
          end else begin
            frame_ok_d  = 1'b1;
            ack_byte_d  = {4'hA, cmd_q};
            accept_load = (cmd_q == CMD_LOAD);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

`ifdef PLANK_FRAME_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    if ((state_q == S_IDLE) || i_rx_dv) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
      to_cnt_d    = '0;
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      ack_dv_d    = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      err_cnt_d   = err_cnt_inc;
      ack_byte_d  = {4'hE, 1'b0, ERR_TIMEOUT};
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
`else
    // No inter-byte timeout: a stalled frame waits for further bytes.
`endif

    // A fresh accepted frame replaces any staged set; the TR edge in the same
    // cycle therefore never commits it.
    if (accept_load) begin
      stg_en_d    = flags_q[2:0];
      stg_defer_d = flags_q[3];
      if (flags_q[0]) stg_attn_d  = sh_attn_q;
      if (flags_q[1]) stg_phase_d = sh_phase_q;
      if (flags_q[2]) stg_pwr_d   = sh_pwr_q;
      if (!flags_q[3] && !i_inhibit) begin
        if (flags_q[0]) attn_d  = sh_attn_q;
        if (flags_q[1]) phase_d = sh_phase_q;
        if (flags_q[2]) pwr_d   = sh_pwr_q;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (pending_q && !i_inhibit && (!stg_defer_q || tr_rise)) begin
      if (stg_en_q[0]) attn_d  = stg_attn_q;
      if (stg_en_q[1]) phase_d = stg_phase_q;
      if (stg_en_q[2]) pwr_d   = stg_pwr_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      flags_q     <= '0;
      cmd_q       <= '0;
      xor_q       <= '0;
      csum_bad_q  <= 1'b0;
      sh_attn_q   <= '0;
      sh_phase_q  <= '0;
      sh_pwr_q    <= '0;
      stg_attn_q  <= '0;
      stg_phase_q <= '0;
      stg_pwr_q   <= '0;
      stg_en_q    <= '0;
      stg_defer_q <= 1'b0;
      pending_q   <= 1'b0;
      attn_q      <= '0;
      phase_q     <= '0;
      pwr_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      err_cnt_q   <= '0;
      ack_dv_q    <= 1'b0;
      ack_byte_q  <= '0;
      tr_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      flags_q     <= flags_d;
      cmd_q       <= cmd_d;
      xor_q       <= xor_d;
      csum_bad_q  <= csum_bad_d;
      sh_attn_q   <= sh_attn_d;
      sh_phase_q  <= sh_phase_d;
      sh_pwr_q    <= sh_pwr_d;
      stg_attn_q  <= stg_attn_d;
      stg_phase_q <= stg_phase_d;
      stg_pwr_q   <= stg_pwr_d;
      stg_en_q    <= stg_en_d;
      stg_defer_q <= stg_defer_d;
      pending_q   <= pending_d;
      attn_q      <= attn_d;
      phase_q     <= phase_d;
      pwr_q       <= pwr_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
      ack_dv_q    <= ack_dv_d;
      ack_byte_q  <= ack_byte_d;
      tr_prev_q   <= tr_prev_d;
    end
  end

`ifdef PLANK_FRAME_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  assign o_attn      = attn_q;
  assign o_phase     = phase_q;
  assign o_ch_power  = pwr_q;
  assign o_frame_ok  = frame_ok_q;
  assign o_frame_err = frame_err_q;
  assign o_err_code  = err_code_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_ack_dv    = ack_dv_q;
  assign o_ack_byte  = ack_byte_q;
  assign o_pending   = pending_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_plank_frame_ctrl.sv
//------------------------------------------------------------------------------
// tb_plank_frame_ctrl
//   Directed-vector self-checking bench for plank_frame_ctrl
//   (timeout scenario selected by PLANK_FRAME_TIMEOUT_EN).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_plank_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tr_pulse = 1'b0;
  logic        inhibit = 1'b0;
  logic [47:0] attn, phase;
  logic [7:0]  ch_power;
  logic        frame_ok, frame_err;
  logic [2:0]  err_code;
  logic [7:0]  err_cnt;
  logic        ack_dv;
  logic [7:0]  ack_byte;
  logic        pending, busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] fr [0:20];

  always #5 clk = ~clk;

  plank_frame_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_rx_dv     (rx_dv),
    .i_rx_byte   (rx_byte),
    .i_TR_pulse  (tr_pulse),
    .i_inhibit   (inhibit),
    .o_attn      (attn),
    .o_phase     (phase),
    .o_ch_power  (ch_power),
    .o_frame_ok  (frame_ok),
    .o_frame_err (frame_err),
    .o_err_code  (err_code),
    .o_err_cnt   (err_cnt),
    .o_ack_dv    (ack_dv),
    .o_ack_byte  (ack_byte),
    .o_pending   (pending),
    .o_busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Frame with 17 identical payload bytes; csum_flip corrupts the checksum.
  task automatic build_frame(input logic [7:0] b1, input logic [7:0] d,
                             input logic [7:0] csum_flip, input logic [7:0] ftr);
    logic [7:0] x;
    x = b1;
    fr[0] = 8'hAA;
    fr[1] = b1;
    for (int i = 2; i <= 18; i++) begin
      fr[i] = d;
      x = x ^ d;
    end
    fr[19] = x ^ csum_flip;
    fr[20] = ftr;
  endtask

  // Returns 1 ns after the edge that sampled the strobe.
  task automatic send_byte(input logic [7:0] b);
    repeat (9) @(posedge clk);
    @(posedge clk); #1;
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_dv   = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(fr[i]);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_attn", attn, 48'h0);
    chk("rst_phase", phase, 48'h0);
    chk("rst_pwr", ch_power, 8'h00);
    chk("rst_pending", pending, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_errcnt", err_cnt, 8'h00);
    chk("rst_errcode", err_code, 3'd0);
    chk("rst_ack", ack_dv, 1'b0);
    rst_n = 1'b1;

    // Deferred commit waits for a TR rising edge.
    build_frame(8'hF2, 8'h37, 8'h00, 8'h55);
    send_range(0, 20);
    chk("def_ok", frame_ok, 1'b1);
    chk("def_ack_dv", ack_dv, 1'b1);
    chk("def_ack", ack_byte, 8'hA2);
    chk("def_pend", pending, 1'b1);
    chk("def_attn_hold", attn, 48'h0);
    repeat (20) @(posedge clk);
    #1;
    chk("def_ok_pulse", frame_ok, 1'b0);
    chk("def_attn_wait", attn, 48'h0);
    tr_pulse = 1'b1;
    @(posedge clk); #1;
    tr_pulse = 1'b0;
    chk("def_attn", attn, {8{6'h37}});
    chk("def_phase", phase, {8{6'h37}});
    chk("def_pwr", ch_power, 8'h37);
    chk("def_pend_clr", pending, 1'b0);

    // Immediate commit; bits [7:6] of attn/phase bytes ignored.
    build_frame(8'h72, 8'hC9, 8'h00, 8'h55);
    send_range(0, 20);
    chk("imm_ok", frame_ok, 1'b1);
    chk("imm_ack", ack_byte, 8'hA2);
    chk("imm_attn", attn, {8{6'h09}});
    chk("imm_phase", phase, {8{6'h09}});
    chk("imm_pwr", ch_power, 8'hC9);
    chk("imm_pend", pending, 1'b0);

    // Bad checksum.
    build_frame(8'hF2, 8'h11, 8'h01, 8'h55);
    send_range(0, 20);
    chk("cs_err", frame_err, 1'b1);
    chk("cs_ok", frame_ok, 1'b0);
    chk("cs_code", err_code, 3'd2);
    chk("cs_ack", ack_byte, 8'hE2);
    chk("cs_cnt", err_cnt, 8'd1);
    chk("cs_attn", attn, {8{6'h09}});
    chk("cs_pend", pending, 1'b0);

    // Unknown command.
    build_frame(8'h15, 8'h11, 8'h00, 8'h55);
    send_range(0, 20);
    chk("cmd_err", frame_err, 1'b1);
    chk("cmd_code", err_code, 3'd3);
    chk("cmd_ack", ack_byte, 8'hE3);
    chk("cmd_cnt", err_cnt, 8'd2);

    // Bad footer takes priority over nothing else wrong.
    build_frame(8'h72, 8'h11, 8'h00, 8'h54);
    send_range(0, 20);
    chk("ftr_err", frame_err, 1'b1);
    chk("ftr_code", err_code, 3'd1);
    chk("ftr_ack", ack_byte, 8'hE1);
    chk("ftr_cnt", err_cnt, 8'd3);
    chk("ftr_pwr", ch_power, 8'hC9);

    // Inhibit holds an immediate commit until it falls.
    inhibit = 1'b1;
    build_frame(8'h72, 8'h05, 8'h00, 8'h55);
    send_range(0, 20);
    chk("inh_ok", frame_ok, 1'b1);
    chk("inh_pend", pending, 1'b1);
    chk("inh_attn", attn, {8{6'h09}});
    repeat (5) @(posedge clk);
    #1;
    chk("inh_attn_wait", attn, {8{6'h09}});
    inhibit = 1'b0;
    @(posedge clk); #1;
    chk("inh_attn_rel", attn, {8{6'h05}});
    chk("inh_pwr_rel", ch_power, 8'h05);
    chk("inh_pend_rel", pending, 1'b0);

    // Only attenuation enabled.
    build_frame(8'h12, 8'h3F, 8'h00, 8'h55);
    send_range(0, 20);
    chk("part_attn", attn, {8{6'h3F}});
    chk("part_phase", phase, {8{6'h05}});
    chk("part_pwr", ch_power, 8'h05);

    // NOP: ack only.
    build_frame(8'h70, 8'h22, 8'h00, 8'h55);
    send_range(0, 20);
    chk("nop_ok", frame_ok, 1'b1);
    chk("nop_ack", ack_byte, 8'hA0);
    chk("nop_attn", attn, {8{6'h3F}});
    chk("nop_pend", pending, 1'b0);

    // Stall after B5.
    build_frame(8'h72, 8'h1A, 8'h00, 8'h55);
    send_range(0, 5);
`ifdef PLANK_FRAME_TIMEOUT_EN
    repeat (17360 - 1) @(posedge clk);
    #1;
    chk("to_early", frame_err, 1'b0);
    chk("to_busy", busy, 1'b1);
    @(posedge clk); #1;
    chk("to_err", frame_err, 1'b1);
    chk("to_code", err_code, 3'd4);
    chk("to_ack", ack_byte, 8'hE4);
    chk("to_cnt", err_cnt, 8'd4);
    chk("to_idle", busy, 1'b0);
    send_range(0, 20);
`else
    repeat (500) @(posedge clk);
    #1;
    chk("stall_busy", busy, 1'b1);
    chk("stall_cnt", err_cnt, 8'd3);
    send_range(6, 20);
`endif
    chk("stall_ok", frame_ok, 1'b1);
    chk("stall_attn", attn, {8{6'h1A}});

    // Reset mid-frame aborts without ack.
    build_frame(8'hF2, 8'h2B, 8'h00, 8'h55);
    send_range(0, 8);
    rst_n = 1'b0;
    #2;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_attn", attn, 48'h0);
    chk("mrst_ack", ack_dv, 1'b0);
    chk("mrst_cnt", err_cnt, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_range(9, 20);
    chk("mrst_noframe", frame_ok | frame_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
